// File: rtl/uart_tx_fifo_if.sv
// Slave bus of the UART TX peripheral: valid/instr/addr/wdata/wstrb request in,
// registered rdata/ready response out one cycle after each valid.
interface uart_tx_fifo_if;
    logic        uart_valid;
    logic        uart_instr;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;

    modport master (
        output uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
        input  uart_rdata, uart_ready
    );

    modport slave (
        input  uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb,
        output uart_rdata, uart_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int DIV_RESET = 868
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_fifo_if.slave bus,
    output logic          uart_tx,
    output logic          uart_irq,
    output logic [2:0]    dbg_state
);
    // Handshake: every cycle with uart_valid=1 is answered by uart_ready=1 on
    // the next cycle with uart_rdata registered alongside; rdata is 0 otherwise.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_BIT = 1'b1;
`else
    localparam logic PAR_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] fdiv_q, fdiv_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    logic [1:0]  sel;
    logic        is_write, push, full, empty, busy, pop, tick, start_frame;
    logic [AW:0] count;
    logic [8:0]  count9;
    logic [7:0]  count_disp;
    logic [7:0]  head;
    logic [15:0] div_new;
    logic [31:0] status;
    logic        unused_ok;

    assign sel      = bus.uart_addr[3:2];
    assign is_write = bus.uart_valid && (bus.uart_wstrb != 4'b0000);
    assign push     = bus.uart_valid && bus.uart_wstrb[0] && (sel == 2'd0);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign busy     = (state_q != S_IDLE);
    assign tick     = (baud_q == 16'd0);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign count    = wr_ptr_q - rd_ptr_q;
    assign count9   = 9'(count);
    assign count_disp = count9[8] ? 8'hFF : count9[7:0];
    assign status   = {16'h0000, count_disp, 3'b000, PAR_BIT, ovf_q, busy, empty, full};
    assign unused_ok = ^{bus.uart_instr, bus.uart_addr[31:4], bus.uart_addr[1:0],
                         bus.uart_wdata[31:16]};

    // Register side: FIFO push, overflow, divisor and the read response.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        div_new  = div_q;
        div_d    = div_q;
        ready_d  = bus.uart_valid;
        rdata_d  = 32'h0;
        if (push) begin
            if (full) ovf_d = 1'b1;
            else      wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (is_write && (sel == 2'd1) && bus.uart_wstrb[0] && bus.uart_wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (bus.uart_wstrb[0]) div_new[7:0]  = bus.uart_wdata[7:0];
        if (bus.uart_wstrb[1]) div_new[15:8] = bus.uart_wdata[15:8];
        if (is_write && (sel == 2'd2)) begin
            div_d = (div_new < 16'd2) ? 16'd2 : div_new;
        end
        if (bus.uart_valid) begin
            case (sel)
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {16'h0000, div_q};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    // Serialiser. The divisor is latched into fdiv at frame start so mid-frame
    // divisor writes only affect the following frame.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        baud_d      = baud_q;
        fdiv_d      = fdiv_q;
        rd_ptr_d    = rd_ptr_q;
        pop         = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_IDLE: start_frame = !empty;
            S_START: begin
                if (tick) begin
                    baud_d  = fdiv_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_d = fdiv_q - 16'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    baud_d  = fdiv_q - 16'd1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d     = S_IDLE;
                    start_frame = !empty;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A frame may begin straight out of STOP, so back-to-back bytes have no gap.
        if (start_frame) begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            shift_d  = head;
            bit_d    = 3'd0;
            baud_d   = div_q - 16'd1;
            fdiv_d   = div_q;
            state_d  = S_START;
`ifdef UART_TX_PARITY_EN
            par_d    = ^head;
`endif
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        irq_d = empty && !busy;
    end

    always_ff @(posedge clock) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= bus.uart_wdata[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            shift_q  <= 8'h00;
            bit_q    <= 3'd0;
            baud_q   <= 16'd0;
            fdiv_q   <= 16'(DIV_RESET);
            div_q    <= 16'(DIV_RESET);
            ovf_q    <= 1'b0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b1;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            fdiv_q   <= fdiv_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign bus.uart_ready = ready_q;
    assign bus.uart_rdata = rdata_q;
    assign uart_tx        = tx_q;
    assign uart_irq       = irq_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: request scoreboard plus a serial-line frame decoder.
module tb_uart_tx_fifo;
  localparam logic [31:0] DIV_RESET = 32'd868;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam logic [31:0] PAR_ST = (NPAR == 1) ? 32'h10 : 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if bus_if ();
  logic uart_tx, uart_irq;
  logic [2:0] dbg_state;

  uart_tx_fifo #(.DEPTH(16), .DIV_RESET(868)) dut (
    .clock(clk), .reset(rst), .bus(bus_if.slave),
    .uart_tx(uart_tx), .uart_irq(uart_irq), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [32:0] exp_q[$];
  int exp_cyc_q[$];
  logic [7:0] txb_q[$];
  int txd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_val(input bit full, input bit empty, input bit busy,
                                             input bit ovf, input int cnt);
    logic [31:0] v;
    v = 32'h0;
    v[0] = full;
    v[1] = empty;
    v[2] = busy;
    v[3] = ovf;
    v[15:8] = 8'(cnt);
    return v | PAR_ST;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit chk, input logic [31:0] expv);
    @(negedge clk);
    bus_if.uart_valid = 1'b1;
    bus_if.uart_instr = 1'b0;
    bus_if.uart_addr  = addr;
    bus_if.uart_wdata = wdata;
    bus_if.uart_wstrb = wstrb;
    exp_q.push_back({chk, expv});
    exp_cyc_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.uart_valid = 1'b0;
      bus_if.uart_wstrb = 4'h0;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    req(addr, data, 4'hF, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expv);
    req(addr, 32'h0, 4'h0, 1'b1, expv);
  endtask

  task automatic wr_tx(input logic [7:0] b, input int d);
    wr(32'h0, {24'h0, b});
    txb_q.push_back(b);
    txd_q.push_back(d);
  endtask

  task automatic wait_irq(input int max_cycles);
    int n;
    n = 0;
    while (uart_irq !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("irq_wait", {31'h0, uart_irq}, 32'h1);
  endtask

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    int c;
    if (bus_if.uart_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_ready: ready=1 with no request outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("ready_latency", cyc, c + 1);
        if (e[32]) check("rdata", bus_if.uart_rdata, e[31:0]);
      end
    end else begin
      check("rdata_idle", bus_if.uart_rdata, 32'h0);
    end
  end

  // ---------------- serial frame monitor ----------------
  initial begin
    logic prev;
    logic [10:0] bits;
    logic [7:0] b;
    int d, nb, errs, first_j;
    bit aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && uart_tx === 1'b0) begin
        if (txb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_frame: start bit with no byte queued (t=%0t)", $time);
          prev = 1'b0;
        end else begin
          b = txb_q.pop_front();
          d = txd_q.pop_front();
          nb = 10 + NPAR;
          bits = '1;
          bits[0] = 1'b0;
          bits[8:1] = b;
          if (NPAR == 1) bits[9] = ^b;
          errs = 0;
          first_j = -1;
          aborted = 1'b0;
          for (int j = 0; j < nb * d; j++) begin
            if (j > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (uart_tx !== bits[j / d]) begin
              if (errs == 0) first_j = j;
              errs++;
            end
          end
          if (!aborted) begin
            total++;
            if (errs != 0) begin
              bad++;
              $display("FAIL tx_frame: byte %h div %0d got %0d wrong cycles, first at %0d, required 0",
                       b, d, errs, first_j);
            end
          end
          prev = aborted ? 1'b1 : uart_tx;
        end
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus_if.uart_valid = 1'b0;
    bus_if.uart_instr = 1'b0;
    bus_if.uart_addr  = 32'h0;
    bus_if.uart_wdata = 32'h0;
    bus_if.uart_wstrb = 4'h0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_irq", {31'h0, uart_irq}, 32'h1);
    check("reset_ready", {31'h0, bus_if.uart_ready}, 32'h0);
    rst = 1'b0;

    // reset register state
    rd(32'h4, status_val(0, 1, 0, 0, 0));
    rd(32'h8, DIV_RESET);
    rd(32'h0, 32'h0);
    rd(32'hC, 32'h0);
    idle(1);

    // single frame 0xA5 at divisor 4, start latency and irq
    wr(32'h8, 32'h4);
    rd(32'h8, 32'h4);
    wr_tx(8'hA5, 4);
    idle(1);
    check("tx_before_start", {31'h0, uart_tx}, 32'h1);
    idle(1);
    check("tx_start_bit", {31'h0, uart_tx}, 32'h0);
    check("irq_busy", {31'h0, uart_irq}, 32'h0);
    wait_irq(100);
    rd(32'h4, status_val(0, 1, 0, 0, 0));
    idle(1);

    // 17 back-to-back bytes at divisor 2, then 2 dropped, then status while full
    wr(32'h8, 32'h2);
    idle(1);
    for (int i = 0; i < 17; i++) wr_tx(8'h30 + 8'(i), 2);
    wr(32'h0, 32'hEE);
    wr(32'h0, 32'hEF);
    rd(32'h4, status_val(1, 0, 1, 1, 16));
    idle(1);
    wait_irq(600);
    rd(32'h4, status_val(0, 1, 0, 1, 0));
    wr(32'h4, 32'h8);
    rd(32'h4, status_val(0, 1, 0, 0, 0));

    // divisor clamping and upper bits
    wr(32'h8, 32'h0);
    rd(32'h8, 32'h2);
    wr(32'h8, 32'h1);
    rd(32'h8, 32'h2);
    wr(32'h8, 32'hFFFF_0010);
    rd(32'h8, 32'h10);
    idle(1);

    // divisor change mid-frame only affects the next frame
    wr(32'h8, 32'h4);
    wr_tx(8'h3C, 4);
    idle(10);
    wr(32'h8, 32'h8);
    wr_tx(8'hC3, 8);
    idle(1);
    wait_irq(400);

    // reset during DATA with overflow set
    wr(32'h8, 32'h4);
    for (int i = 0; i < 17; i++) wr_tx(8'h50 + 8'(i), 4);
    wr(32'h0, 32'h99);
    rd(32'h4, status_val(1, 0, 1, 1, 16));
    idle(1);
    n = 0;
    while (dbg_state !== 3'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_data", {29'h0, dbg_state}, 32'h2);
    #2 rst = 1'b1;
    #1;
    check("tx_async_reset", {31'h0, uart_tx}, 32'h1);
    check("irq_async_reset", {31'h0, uart_irq}, 32'h1);
    txb_q.delete();
    txd_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(32'h4, status_val(0, 1, 0, 0, 0));
    rd(32'h8, DIV_RESET);
    idle(5);
    check("tx_idle_after_reset", {31'h0, uart_tx}, 32'h1);

    check("resp_queue_empty", exp_q.size(), 32'h0);
    check("tx_queue_empty", txb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
